// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: shared state encoding and default sizing for the mult_acc_8 stage
package mult_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int N_DEF       = 8;
    localparam int N_TERMS_DEF = 16;
    localparam int ACC_W_DEF   = 20;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/mult_acc_8_if.sv
// mult_acc_8_if: operand input stream, result output stream and flush for mult_acc_8
interface mult_acc_8_if
    import mult_acc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic             ovf;

    modport master (
        output clr, in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  clr, in_valid, a, b, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/mult_tree_8.sv
// mult_tree_8: combinational unsigned 8x8 multiplier built as a partial-product adder tree
module mult_tree_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp [8];
    logic [15:0] s1 [4];
    logic [15:0] s2 [2];

    for (genvar i = 0; i < 8; i++) begin : g_pp
        assign pp[i] = b[i] ? ({8'd0, a} << i) : 16'd0;
    end

    for (genvar i = 0; i < 4; i++) begin : g_s1
        assign s1[i] = pp[2*i] + pp[2*i+1];
    end

    for (genvar i = 0; i < 2; i++) begin : g_s2
        assign s2[i] = s1[2*i] + s1[2*i+1];
    end

    assign p = s2[0] + s2[1];
endmodule

// File: rtl/mult_acc_8.sv
// mult_acc_8: pipelined multiply-accumulate producing one N_TERMS dot product per handshake.
// Optional MULT_ACC_8_SATURATE_EN: clamp the accumulator at all-ones on carry instead of wrapping.
module mult_acc_8
    import mult_acc_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int ACC_W   = ACC_W_DEF
) (
    input logic         clk,
    input logic         rst,
    mult_acc_8_if.slave bus
);
    state_t           state_q, state_d;
    logic [N-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [2*N-1:0]   prod_q, prod_d, p;
    logic [ACC_W-1:0] acc_q, acc_d, acc_new, result_q, result_d;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d, add_cnt_q, add_cnt_d;
    logic             out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic             in_ready, accept, carry, last, handoff, flush;

    mult_tree_8 u_mult (
        .a (op_a_q),
        .b (op_b_q),
        .p (p)
    );

    assign accept  = bus.in_valid && in_ready;
    assign sum     = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    assign carry   = sum[ACC_W];
    assign last    = v2_q && (state_q == ACCUM) && (add_cnt_q == CNT_W'(N_TERMS - 1));
    assign handoff = (state_q == HOLD) && out_valid_q && bus.out_ready;
    assign flush   = bus.clr || handoff;

`ifdef MULT_ACC_8_SATURATE_EN
    assign acc_new = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_new = sum[ACC_W-1:0];
`endif

    // state and pipeline registers; rst discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            op_a_q      <= '0;
            op_b_q      <= '0;
            v1_q        <= 1'b0;
            prod_q      <= '0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            issue_cnt_q <= '0;
            add_cnt_q   <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            v1_q        <= v1_d;
            prod_q      <= prod_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            issue_cnt_q <= issue_cnt_d;
            add_cnt_q   <= add_cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // next state: clr wins, final add enters HOLD, result handoff returns to ACCUM
    always_comb begin
        state_d = bus.clr ? ACCUM :
                  last    ? HOLD  :
                  handoff ? ACCUM : state_q;
    end

    // datapath: operand capture, product register, accumulate, counts and result latch
    always_comb begin
        op_a_d      = accept ? bus.a : op_a_q;
        op_b_d      = accept ? bus.b : op_b_q;
        v1_d        = accept;
        prod_d      = v1_q ? p : prod_q;
        v2_d        = v1_q && !bus.clr;
        issue_cnt_d = flush ? '0 : issue_cnt_q + CNT_W'(accept);
        add_cnt_d   = flush ? '0 : add_cnt_q + CNT_W'(v2_q);
        acc_d       = flush ? '0 : v2_q ? acc_new : acc_q;
        ovf_d       = flush ? 1'b0 : ovf_q || (v2_q && carry);
        result_d    = (last && !bus.clr) ? acc_new : result_q;
        out_valid_d = flush ? 1'b0 : last ? 1'b1 : out_valid_q;
    end

    // outputs: issue only while accumulating with terms left, never during rst or clr
    always_comb begin
        in_ready      = (state_q == ACCUM) && (issue_cnt_q < CNT_W'(N_TERMS)) && !rst && !bus.clr;
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid_q;
        bus.result    = result_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_mult_acc_8.sv
// tb_mult_acc_8: table-driven and hand-sequenced checks of mult_acc_8 over four parameter sets
module tb_mult_acc_8;
    typedef struct {
        int          d;
        logic [7:0]  a;
        logic [7:0]  b;
        int          gap;
        bit          last;
        logic [19:0] exp_res;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        int          d;
        logic [19:0] r;
        bit          o;
    } exp_t;

    logic        clk = 0;
    logic        rst;
    logic        clr_s [4];
    logic        iv    [4];
    logic        or_s  [4];
    logic [7:0]  a_s   [4];
    logic [7:0]  b_s   [4];
    logic        ir    [4];
    logic        ov    [4];
    logic        of    [4];
    logic [19:0] res   [4];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];
    exp_t mon_e;
    vec_t vecs [$];

    always #5 clk = ~clk;

    mult_acc_8_if #(.N(8), .ACC_W(20)) if0 ();
    mult_acc_8_if #(.N(8), .ACC_W(20)) if1 ();
    mult_acc_8_if #(.N(8), .ACC_W(16)) if2 ();
    mult_acc_8_if #(.N(8), .ACC_W(20)) if3 ();

    assign if0.clr = clr_s[0]; assign if0.in_valid = iv[0]; assign if0.a = a_s[0];
    assign if0.b = b_s[0];     assign if0.out_ready = or_s[0];
    assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign of[0] = if0.ovf;
    assign res[0] = if0.result;

    assign if1.clr = clr_s[1]; assign if1.in_valid = iv[1]; assign if1.a = a_s[1];
    assign if1.b = b_s[1];     assign if1.out_ready = or_s[1];
    assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign of[1] = if1.ovf;
    assign res[1] = if1.result;

    assign if2.clr = clr_s[2]; assign if2.in_valid = iv[2]; assign if2.a = a_s[2];
    assign if2.b = b_s[2];     assign if2.out_ready = or_s[2];
    assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign of[2] = if2.ovf;
    assign res[2] = {4'd0, if2.result};

    assign if3.clr = clr_s[3]; assign if3.in_valid = iv[3]; assign if3.a = a_s[3];
    assign if3.b = b_s[3];     assign if3.out_ready = or_s[3];
    assign ir[3] = if3.in_ready; assign ov[3] = if3.out_valid; assign of[3] = if3.ovf;
    assign res[3] = if3.result;

    mult_acc_8 #(.N(8), .N_TERMS(16), .ACC_W(20)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mult_acc_8 #(.N(8), .N_TERMS(4),  .ACC_W(20)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mult_acc_8 #(.N(8), .N_TERMS(2),  .ACC_W(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    mult_acc_8 #(.N(8), .N_TERMS(3),  .ACC_W(20)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    // scoreboard: every completed output handshake must match the oldest expected result
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (!rst && ov[d] && or_s[d]) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out dut%0d result=%0d ovf=%0b", d, res[d], of[d]);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.d != d || res[d] !== mon_e.r || of[d] !== mon_e.o) begin
                        n_bad++;
                        $display("FAIL result dut%0d got %0d ovf=%0b, expected dut%0d %0d ovf=%0b",
                                 d, res[d], of[d], mon_e.d, mon_e.r, mon_e.o);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // called just after a rising edge; returns just after the edge that accepted the pair
    task automatic send(input int d, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        iv[d] = 1; a_s[d] = a; b_s[d] = b;
        @(negedge clk);
        while (!ir[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", 32'(t < 200), 1);
        step();
        iv[d] = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", sb.size(), 0);
        step();
    endtask

    task automatic run_rand(input int d, input int n);
        logic [19:0] sum = 0;
        logic [7:0]  a, b;
        exp_t        e;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            sum += 20'(a) * 20'(b);
            if (i == n - 1) begin
                e.d = d; e.r = sum; e.o = 0;
                sb.push_back(e);
            end
            send(d, a, b);
        end
        wait_drain();
    endtask

    task automatic add_vec(input int d, input logic [7:0] a, input logic [7:0] b, input int gap,
                           input bit last, input logic [19:0] r, input bit o);
        vec_t v;
        v.d = d; v.a = a; v.b = b; v.gap = gap; v.last = last; v.exp_res = r; v.exp_ovf = o;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [19:0] bp_sum;
        logic [7:0]  x, y;
        int          t;

        add_vec(1, 1, 2, 0, 0, 0, 0);
        add_vec(1, 3, 4, 0, 0, 0, 0);
        add_vec(1, 5, 6, 0, 0, 0, 0);
        add_vec(1, 7, 8, 0, 1, 100, 0);
        for (int i = 0; i < 4; i++) add_vec(1, 0, 0, 0, i == 3, 0, 0);
        add_vec(1, 255, 1, 0, 0, 0, 0);
        add_vec(1, 1, 255, 0, 0, 0, 0);
        add_vec(1, 128, 2, 0, 0, 0, 0);
        add_vec(1, 16, 16, 0, 1, 1022, 0);
        for (int i = 0; i < 16; i++) add_vec(0, 255, 255, 0, i == 15, 1040400, 0);
        add_vec(2, 255, 255, 0, 0, 0, 0);
`ifdef MULT_ACC_8_SATURATE_EN
        add_vec(2, 255, 255, 0, 1, 20'hFFFF, 1);
`else
        add_vec(2, 255, 255, 0, 1, 20'hFC02, 1);
`endif
        add_vec(2, 100, 100, 0, 0, 0, 0);
        add_vec(2, 50, 50, 0, 1, 12500, 0);
        add_vec(3, 2, 3, 0, 0, 0, 0);
        add_vec(3, 4, 5, 2, 0, 0, 0);
        add_vec(3, 10, 10, 1, 1, 126, 0);

        rst = 1;
        for (int d = 0; d < 4; d++) begin
            clr_s[d] = 0; iv[d] = 0; or_s[d] = 1; a_s[d] = 0; b_s[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_in_ready%0d", d), 32'(ir[d]), 0);
            chk($sformatf("rst_out_valid%0d", d), 32'(ov[d]), 0);
            chk($sformatf("rst_result%0d", d), 32'(res[d]), 0);
            chk($sformatf("rst_ovf%0d", d), 32'(of[d]), 0);
        end
        step();
        rst = 0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk($sformatf("post_rst_in_ready%0d", d), 32'(ir[d]), 1);
        step();

        foreach (vecs[i]) begin
            repeat (vecs[i].gap) step();
            if (vecs[i].last) begin
                e.d = vecs[i].d; e.r = vecs[i].exp_res; e.o = vecs[i].exp_ovf;
                sb.push_back(e);
            end
            send(vecs[i].d, vecs[i].a, vecs[i].b);
            if (vecs[i].last) begin
                @(negedge clk);
                @(negedge clk);
                chk($sformatf("lat_early_v%0d", i), 32'(ov[vecs[i].d]), 0);
                @(negedge clk);
                chk($sformatf("lat_pulse_v%0d", i), 32'(ov[vecs[i].d]), 1);
                chk($sformatf("handoff_ready_low_v%0d", i), 32'(ir[vecs[i].d]), 0);
                step();
                @(negedge clk);
                chk($sformatf("pulse_end_v%0d", i), 32'(ov[vecs[i].d]), 0);
                chk($sformatf("ready_back_v%0d", i), 32'(ir[vecs[i].d]), 1);
                step();
            end
        end

        or_s[0] = 0;
        bp_sum = 0;
        for (int i = 0; i < 16; i++) begin
            x = 8'(i * 13 + 7);
            y = 8'(255 - i * 5);
            bp_sum += 20'(x) * 20'(y);
            if (i == 15) begin
                e.d = 0; e.r = bp_sum; e.o = 0;
                sb.push_back(e);
            end
            send(0, x, y);
        end
        t = 0;
        @(negedge clk);
        while (!ov[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_wait_valid", 32'(ov[0]), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(ov[0]), 1);
            chk("bp_hold_result", 32'(res[0]), 32'(bp_sum));
            chk("bp_in_ready", 32'(ir[0]), 0);
            @(negedge clk);
        end
        step();
        or_s[0] = 1;
        @(negedge clk);
        chk("bp_handoff_ready", 32'(ir[0]), 0);
        step();
        @(negedge clk);
        chk("bp_ready_rise", 32'(ir[0]), 1);
        chk("bp_valid_drop", 32'(ov[0]), 0);
        step();
        run_rand(0, 16);
        run_rand(1, 4);

        send(1, 9, 9);
        send(1, 9, 9);
        clr_s[1] = 1; iv[1] = 1; a_s[1] = 50; b_s[1] = 50;
        @(negedge clk);
        chk("clr_in_ready", 32'(ir[1]), 0);
        step();
        clr_s[1] = 0; iv[1] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clr_no_out", 32'(ov[1]), 0);
        end
        chk("clr_ready_back", 32'(ir[1]), 1);
        step();
        e.d = 1; e.r = 4; e.o = 0;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) send(1, 1, 1);
        wait_drain();

        send(1, 9, 9);
        send(1, 9, 9);
        rst = 1; iv[1] = 1; a_s[1] = 50; b_s[1] = 50;
        @(negedge clk);
        chk("rst_mid_in_ready", 32'(ir[1]), 0);
        step();
        rst = 0; iv[1] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_no_out", 32'(ov[1]), 0);
        end
        chk("rst_mid_result", 32'(res[1]), 0);
        chk("rst_mid_ready_back", 32'(ir[1]), 1);
        step();
        e.d = 1; e.r = 4; e.o = 0;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) send(1, 1, 1);
        wait_drain();

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
